dm_bridge: RTL and testbench

//  Data-memory access bridge between the multi-cycle CPU datapath and a slow, handshaked data memory.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/dm_lane_unit.sv | 25 ++
 rtl/dm_bridge.sv | 101 ++++++++++
 tb/tb_dm_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared FSM encoding and byte-lane helpers for the data-memory bridge
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Little-endian lane select: lane 0 is bits [7:0].
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        return shifted[7:0];
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// rtl/dm_lane_unit.sv - byte-enable generation, sb data replication and lb extract/sign-extend
module dm_lane_unit
    import mips_pkg::*;
(
    input  logic        is_byte,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data
);

    always_comb begin
        be        = 4'b1111;
        mem_wdata = wdata;
        load_data = rdata;
        if (is_byte) begin
            be        = 4'b0001 << lane;
            mem_wdata = {4{wdata[7:0]}};
            load_data = sext8(lane_byte(rdata, lane));
        end
    end

endmodule

// File: rtl/dm_bridge.sv
// rtl/dm_bridge.sv - handshaked data-memory bridge: one lw/sw/lb/sb per request with ack timeout
module dm_bridge
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              we_q, byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, lane_load;
    logic              in_access, timeout_hit;

    dm_lane_unit u_lane (
        .is_byte   (byte_q),
        .lane      (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .be        (lane_be),
        .mem_wdata (lane_wdata),
        .load_data (lane_load)
    );

    assign in_access   = (state_q == ACCESS);
    // The last permitted wait cycle passes without ack: abort instead of counting on.
    assign timeout_hit = in_access && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req) state_d = ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            cpu_rdata <= '0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cpu_req) begin
                we_q    <= cpu_we;
                byte_q  <= cpu_byte;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                cnt_q   <= '0;
            end
            if (in_access) begin
                if (mem_ack) begin
                    if (!we_q) cpu_rdata <= lane_load;
                end else if (timeout_hit) begin
                    err <= 1'b1;
                    if (!we_q) cpu_rdata <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign cpu_ready = (state_q == DONE);
    assign mem_req   = in_access;
    assign mem_we    = in_access && we_q;
    assign mem_be    = in_access ? lane_be : 4'b0000;
    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_wdata = lane_wdata;

endmodule

// File: tb/tb_dm_bridge.sv
// tb/tb_dm_bridge.sv - randomized self-checking bench for dm_bridge against a transaction-level model
module tb_dm_bridge;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack, err;

    dm_bridge #(.ADDR_W(10), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Current transaction expectations (cycle numbers as counted by the compare process)
    int          t_lo = -10, t_hi = -11, t_ready = -1;
    bit          t_we, t_to;
    logic [31:0] t_load, t_wd;
    logic [3:0]  t_be;
    logic [7:0]  t_addr;
    logic [31:0] m_rdata = 0;
    bit          m_err = 0;

    int          last_ready = -1, prev_ready = -1, ready_cnt = 0;
    logic [3:0]  seen_be;
    logic [31:0] seen_wd;
    logic        seen_we;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Compare process: every cycle, 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == t_ready) begin
                if (!t_we) m_rdata = t_to ? 32'h0 : t_load;
                if (t_to) m_err = 1'b1;
            end
            if (cpu_ready === 1'b1) begin
                prev_ready = last_ready;
                last_ready = cyc;
                ready_cnt++;
            end
            chk("cpu_ready", {31'b0, cpu_ready}, {31'b0, (cyc == t_ready)});
            chk("mem_req", {31'b0, mem_req}, {31'b0, (cyc >= t_lo && cyc <= t_hi)});
            chk("cpu_rdata", cpu_rdata, m_rdata);
            chk("err", {31'b0, err}, {31'b0, m_err});
            if (cyc >= t_lo && cyc <= t_hi) begin
                chk("mem_addr", {24'b0, mem_addr}, {24'b0, t_addr});
                chk("mem_be", {28'b0, mem_be}, {28'b0, t_be});
                chk("mem_we", {31'b0, mem_we}, {31'b0, t_we});
                if (t_we) chk("mem_wdata", mem_wdata, t_wd);
                seen_be = mem_be;
                seen_wd = mem_wdata;
                seen_we = mem_we;
            end
        end
    end

    // Issue one access from IDLE (called at a falling edge); w >= TIMEOUT means never ack.
    task automatic do_txn(input bit we, input bit byt, input logic [9:0] addr,
                          input logic [31:0] wd, input logic [31:0] word,
                          input int w, input bit hold, output int c);
        int lane, b;
        c         = cyc;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_byte  = byt;
        cpu_addr  = addr;
        cpu_wdata = wd;
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        lane      = int'(addr % 4);
        b         = int'((word >> (8 * lane)) & 32'hFF);
        t_load    = byt ? ((b >= 128) ? 32'(b - 256) : 32'(b)) : word;
        t_we      = we;
        t_to      = (w >= TIMEOUT);
        t_be      = byt ? 4'(1 << lane) : 4'hF;
        t_wd      = byt ? {4{wd[7:0]}} : wd;
        t_addr    = 8'(addr / 4);
        t_lo      = c + 1;
        t_hi      = c + 1 + (t_to ? TIMEOUT - 1 : w);
        t_ready   = t_hi + 1;
        while (1) begin
            @(negedge clk);
            if (cyc == c + 1 && !hold) cpu_req = 1'b0;
            if (cyc == t_ready + 1) break;
            if (!t_to && cyc == c + 1 + w) begin
                mem_ack   = 1'b1;
                mem_rdata = word;
            end else if (cyc == t_ready) begin
                mem_ack   = $urandom_range(0, 1) == 1;
                mem_rdata = $urandom;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        int c, c2, rc;
        rst = 1'b0; cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        #1;
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_ready", {31'b0, cpu_ready}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", {24'b0, mem_addr}, 32'h0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_txn(0, 0, 10'h010, 32'h0, 32'h12345678, 0, 0, c);
        chk("lw_latency", last_ready - c, 2);
        chk("lw_be", {28'b0, seen_be}, 32'hF);
        chk("lw_rdata", cpu_rdata, 32'h12345678);

        do_txn(0, 1, 10'h013, 32'h0, 32'h80FF0011, 1, 0, c);
        chk("lb_neg", cpu_rdata, 32'hFFFFFF80);
        do_txn(0, 1, 10'h011, 32'h0, 32'h80FF0011, 2, 0, c);
        chk("lb_zero", cpu_rdata, 32'h00000000);
        idle(2);

        do_txn(0, 0, 10'h024, 32'h0, 32'hDEADBEEF, 2, 0, c);
        do_txn(1, 1, 10'h002, 32'h000000AB, 32'h0, 0, 0, c);
        chk("sb_be", {28'b0, seen_be}, 32'h4);
        chk("sb_wdata", seen_wd, 32'hABABABAB);
        chk("sb_we", {31'b0, seen_we}, 32'h1);
        chk("sb_keeps_rdata", cpu_rdata, 32'hDEADBEEF);

        do_txn(0, 0, 10'h020, 32'h0, 32'h0, TIMEOUT, 0, c);
        chk("to_latency", last_ready - c, 16);
        chk("to_err", {31'b0, err}, 32'h1);
        chk("to_rdata", cpu_rdata, 32'h0);
        do_txn(0, 0, 10'h030, 32'h0, 32'hCAFEF00D, 14, 0, c);
        chk("after_to_rdata", cpu_rdata, 32'hCAFEF00D);
        chk("after_to_err", {31'b0, err}, 32'h1);

        // Reset during ACCESS with ack planned 3 cycles in
        rc = ready_cnt;
        c = cyc;
        cpu_req = 1'b1; cpu_we = 0; cpu_byte = 0; cpu_addr = 10'h040;
        t_lo = c + 1; t_hi = c + 4; t_ready = -1; t_we = 0; t_be = 4'hF; t_addr = 8'h10;
        @(negedge clk); cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        t_lo = -10; t_hi = -11; t_ready = -1; m_rdata = 0; m_err = 0;
        #1;
        chk("rst_mid_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mid_err", {31'b0, err}, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk); mem_ack = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_ready", ready_cnt, rc);

        // Back-to-back with cpu_req held high
        rc = ready_cnt;
        do_txn(0, 0, 10'h050, 32'h0, 32'h0BADF00D, 3, 1, c);
        do_txn(0, 1, 10'h051, 32'h0, 32'h00007F00, 3, 0, c2);
        chk("b2b_count", ready_cnt - rc, 2);
        chk("b2b_spacing", last_ready - prev_ready, 6);
        chk("b2b_rdata", cpu_rdata, 32'h0000007F);

        for (int i = 0; i < 200; i++) begin
            int w, gap;
            w   = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            do_txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 10'($urandom),
                   $urandom, $urandom, w, gap == 0, c);
            idle(gap);
        end
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
